// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg                                                          |
// | Shared sizing constants and output-stage state encoding.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package regfile_pkg;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_storage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_storage                                                      |
// | Register array with one write port and two combinational read ports. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_storage #(
    parameter int WIDTH  = regfile_pkg::WIDTH,
    parameter int DEPTH  = regfile_pkg::DEPTH,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b
);
    import regfile_pkg::*;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;
    logic             w_rd_ok_a;
    logic             w_rd_ok_b;

    // Index 0 is hardwired to zero; out-of-range indices behave like it.
    assign w_wr_ok   = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < c_depth);
    assign w_rd_ok_a = (rd_addr_a != '0) && ({1'b0, rd_addr_a} < c_depth);
    assign w_rd_ok_b = (rd_addr_b != '0) && ({1'b0, rd_addr_b} < c_depth);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = w_rd_ok_a ? r_mem[rd_addr_a] : '0;
    assign rd_data_b = w_rd_ok_b ? r_mem[rd_addr_b] : '0;

endmodule
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_read_port                                                    |
// | Two-port register file read with write bypass and a stallable stage. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_read_port #(
    parameter int WIDTH  = regfile_pkg::WIDTH,
    parameter int DEPTH  = regfile_pkg::DEPTH,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              rd_hold,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              busy
);
    import regfile_pkg::*;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] w_stor_a;
    logic [WIDTH-1:0] w_stor_b;
    logic             w_byp_a;
    logic             w_byp_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    rd_state_e        r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_data_a;
    logic [WIDTH-1:0] r_data_b;

    regfile_storage #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (w_stor_a),
        .rd_data_b (w_stor_b)
    );

    // Forward a same-cycle write only where the storage would accept it.
    assign w_byp_a = wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != '0)
                     && ({1'b0, rd_addr_a} < c_depth);
    assign w_byp_b = wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != '0)
                     && ({1'b0, rd_addr_b} < c_depth);
    assign w_rd_a  = w_byp_a ? wr_data : w_stor_a;
    assign w_rd_b  = w_byp_b ? wr_data : w_stor_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_data_a <= '0;
            r_data_b <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd_req) begin
                        r_state  <= VALID;
                        r_valid  <= 1'b1;
                        r_data_a <= w_rd_a;
                        r_data_b <= w_rd_b;
                    end
                end
                VALID: begin
                    // A held output drops any incoming request.
                    if (!rd_hold) begin
                        if (rd_req) begin
                            r_data_a <= w_rd_a;
                            r_data_b <= w_rd_b;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rd_valid  = r_valid;
    assign rd_data_a = r_data_a;
    assign rd_data_b = r_data_b;
    assign busy      = r_valid & rd_hold;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_read_port                                                 |
// | Directed vectors with a queue-based scoreboard and negedge monitor.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_regfile_read_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        rd_hold;
    logic        rd_valid;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        busy;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    regfile_read_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_hold   (rd_hold),
        .rd_valid  (rd_valid),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy      (busy)
    );

    // Outputs are sampled mid-cycle, after the inputs for the next edge settle.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got rd_valid=1 a=%h b=%h, want rd_valid=0",
                         rd_data_a, rd_data_b);
            end else begin
                e = q.pop_front();
                if (rd_data_a !== e.a || rd_data_b !== e.b || busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL read_data: got a=%h b=%h busy=%b, want a=%h b=%h busy=%b",
                             rd_data_a, rd_data_b, busy, e.a, e.b, e.busy);
                end
            end
        end else begin
            n_tests++;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_fail++;
                $display("FAIL missing_valid: got rd_valid=%b busy=%b, want valid with a=%h b=%h",
                         rd_valid, busy, e.a, e.b);
            end else if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_busy: got busy=%b, want 0", busy);
            end
        end
    end

    // Drive one cycle of inputs; ev/ea/eb describe the outputs visible during it.
    task automatic step(input logic rn, input logic req, input logic [4:0] a,
                        input logic [4:0] b, input logic hold, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic ev, input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        rst_n     = rn;
        rd_req    = req;
        rd_addr_a = a;
        rd_addr_b = b;
        rd_hold   = hold;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        if (ev) begin
            e.a    = ea;
            e.b    = eb;
            e.busy = hold;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want run to complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        step(0, 1, 5, 5, 0, 1, 5, 32'h1111_1111, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0);
        n_tests++;
        if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b a=%h b=%h, want 0 0 0",
                     rd_valid, rd_data_a, rd_data_b);
        end

        // Plain write then read; r0 on port B
        step(1, 0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0,             0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 32'h0);
        // r0 write discarded
        step(1, 1, 0, 5, 0, 0, 0, 0,             0, 0, 0);
        // Bypass on both ports in the same cycle as the write
        step(1, 1, 7, 7, 0, 1, 7, 32'h1234_5678, 1, 32'h0, 32'hDEAD_BEEF);
        step(1, 0, 0, 0, 0, 0, 0, 0,             1, 32'h1234_5678, 32'h1234_5678);

        // Hold for 3 cycles; r6 request during hold is dropped
        step(1, 1, 5, 5, 0, 0, 0, 0,             0, 0, 0);
        step(1, 1, 6, 6, 1, 1, 6, 32'h0000_0066, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step(1, 1, 6, 6, 1, 0, 0, 0,             1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step(1, 1, 6, 6, 1, 0, 0, 0,             1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step(1, 0, 0, 0, 0, 0, 0, 0,             1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step(1, 0, 0, 0, 1, 0, 0, 0,             0, 0, 0);
        // The write during hold did land
        step(1, 1, 6, 0, 0, 0, 0, 0,             0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0,             1, 32'h0000_0066, 32'h0);

        // Reset mid-hold, with competing read and write
        step(1, 1, 5, 5, 0, 0, 0, 0,             0, 0, 0);
        step(0, 1, 5, 9, 1, 1, 9, 32'h9999_9999, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step(1, 1, 5, 9, 1, 0, 0, 0,             0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0,             1, 32'h0, 32'h0);

        // Fill r0..r31 with index*3, then read back-to-back
        for (int i = 0; i < 32; i++) begin
            step(1, 0, 0, 0, 0, 1, 5'(i), 32'(i * 3), 0, 0, 0);
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 0)
                step(1, 1, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0, 0);
            else
                step(1, 1, 5'(i), 5'(31 - i), 0, 0, 0, 0,
                     1, 32'((i - 1) * 3), 32'((32 - i) * 3));
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'(31 * 3), 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_read_port.md
REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001: Parameter WIDTH, default 32, data word width in bits.
REQ-002: Parameter DEPTH, default 32, number of registers; ADDR_W = log2(DEPTH), default 5.
REQ-003: clk  input  1  clock; all state updates on posedge clk.
REQ-004: rst_n  input  1  reset, synchronous and active-low.
REQ-005: wr_en  input  1  write strobe for the write port.
REQ-006: wr_addr  input  ADDR_W  register index to write.
REQ-007: wr_data  input  WIDTH  data to write.
REQ-008: rd_req  input  1  read request; samples rd_addr_a and rd_addr_b.
REQ-009: rd_addr_a, rd_addr_b  input  ADDR_W each  read indices for ports A and B.
REQ-010: rd_hold  input  1  consumer stall; freezes the output stage.
REQ-011: rd_valid  output  1  rd_data_a and rd_data_b carry a completed read.
REQ-012: rd_data_a, rd_data_b  output  WIDTH each  registered read data.
REQ-013: busy  output  1  high while a read is held and not yet consumed.

Function
REQ-014: Writes commit on posedge clk when wr_en=1 and rst_n=1, except that writes to index 0 are discarded.
REQ-015: Register 0 reads as 0 on both ports at all times.
REQ-016: Read latency is exactly 1 cycle: a rd_req accepted at edge N produces rd_valid=1 with data after edge N.
REQ-017: The output stage has two states:
- IDLE: rd_valid=0.
- VALID: rd_valid=1.
REQ-018: Transitions:
- IDLE to VALID when rd_req=1.
- VALID to VALID with new data when rd_req=1 and rd_hold=0.
- VALID to IDLE when rd_req=0 and rd_hold=0.
- VALID holds its state, data and valid when rd_hold=1.
REQ-019: rd_req is ignored while state is VALID and rd_hold=1; no request is queued.
REQ-020: busy = rd_valid AND rd_hold.
REQ-021: Read-during-write bypass: if wr_en=1 and wr_addr equals a sampled read address (nonzero) in the same cycle, that port returns wr_data.
REQ-022: Ports A and B may address the same register and both return identical data.
REQ-023: rd_hold is ignored in IDLE.
REQ-024: Out-of-range addresses (>= DEPTH, when DEPTH is not a power of two) read 0 and discard writes.

Reset
REQ-025: When rst_n=0 at posedge clk:
- all registers clear to 0;
- the output stage goes to IDLE with rd_valid=0, rd_data_a=0, rd_data_b=0 and busy=0.
REQ-026: Reset has priority over wr_en and rd_req arriving in the same cycle, including mid-hold; the pending read is dropped.
REQ-027: Reads are accepted starting with the first edge at which rst_n=1.

Structure
REQ-028: A shared package regfile_pkg holds WIDTH, DEPTH, ADDR_W and the output-stage state enum (IDLE, VALID).
REQ-029: The storage array is one sub-module, regfile_storage, providing a write port and two combinational read ports; regfile_read_port adds the bypass logic and the output stage.

Verification
REQ-030: Write 0xDEADBEEF to r5, then rd_req with a=5, b=0 on the next cycle -> one cycle later rd_valid=1, rd_data_a=0xDEADBEEF, rd_data_b=0.
REQ-031: wr_en to r0 with 0xFFFFFFFF, then read a=0 -> rd_data_a=0.
REQ-032: Same cycle: wr_en r7=0x12345678 and rd_req a=7, b=7 -> next cycle both ports =0x12345678 (bypass).
REQ-033: Read r5, then hold rd_hold=1 for 3 cycles while issuing rd_req a=6 -> data stays 0xDEADBEEF, busy=1, and the r6 request is lost; release hold with rd_req=0 -> IDLE.
REQ-034: Drive rst_n=0 while in VALID/hold -> next edge rd_valid=0, busy=0, and a read of r5 afterwards returns 0.
REQ-035: Back-to-back rd_req over 32 cycles reading r0..r31 after writing each with its index times 3 -> each result appears exactly 1 cycle later, with r0=0.
